adder_stimulus_gen: RTL and testbench
=====================================

# adder_stimulus_gen

Self-checking stimulus source for the adder test bench. It drives operands `a`, `b` and `cin` into the adder under test, one vector per cycle. It also produces the matching expected sum `ref`, delayed to line up with the adder's registered `result`. The block sits upstream of the adder and feeds both the adder and the result comparator: `ref` and `ref_valid` connect directly to the comparator's reference input and gate its check.

## Interface
- `WIDTH`, 16: operand width. Supported range is 1..16. `ref` is `WIDTH+1` bits.
- `LATENCY`, 1: cycles from operands to the adder's `result`. `ref` is delayed by exactly this amount. 0 is legal.
- `NUM_RANDOM`, 64: number of pseudo-random vectors applied after the corner set. 0 is legal.
- `SEED`, 32'hACE1_2468: LFSR load value. Must be non-zero.
- `clk`, input, 1: single clock. All state changes on its rising edge.
- `rst`, input, 1: asynchronous, active-high reset.
- `start`, input, 1: sampled in IDLE or DONE; begins a run.
- `a`, output, `WIDTH`: operand A (registered).
- `b`, output, `WIDTH`: operand B (registered).
- `cin`, output, 1: carry-in (registered).
- `ref`, output, `WIDTH+1`: expected `a+b+cin`, delayed by `LATENCY`.
- `ref_valid`, output, 1: `ref` corresponds to an applied vector.
- `busy`, output, 1: a run is in progress.
- `done`, output, 1: run complete. Sticky until the next `start`.
- `vec_count`, output, 16: vectors applied in the current run.

## Operation
- States and transitions:
  - IDLE → CORNER on `start`.
  - CORNER applies 6 vectors, then goes to RANDOM.
  - RANDOM applies `NUM_RANDOM` vectors, then goes to DRAIN.
  - DRAIN waits `LATENCY` cycles, then goes to DONE.
  - DONE → CORNER on `start`.
- Corner vectors, in order (`a`, `b`, `cin`):
  - (0, 0, 0)
  - (all-ones, 1, 0)
  - (all-ones, all-ones, 1)
  - (alt, ~alt, 0), where alt is ...1010 (bit 0 = 0)
  - (alt, ~alt, 1)
  - (MSB-only, MSB-only, 0)
- Random vectors use a 32-bit Galois LFSR with mask 32'h8020_0003:
  - Step: `lsb=l[0]; l=l>>1; if lsb, l^=mask`.
  - Each vector takes `a=l[WIDTH-1:0]`, `b=l[16+WIDTH-1:16]`, `cin=l[31]^l[0]`, then steps once.
  - The LFSR is reloaded with `SEED` on every `start` and on reset, so every run is reproducible.
- Outside CORNER and RANDOM, `a`, `b` and `cin` are driven to 0 and the valid bit entering the delay line is 0.
- Reference sum is computed at full width: `{1'b0,a}+{1'b0,b}+cin`, `WIDTH+1` bits, with no truncation of the carry-out.
- `vec_count` clears on `start` and increments once per applied vector. At DONE it holds `6+NUM_RANDOM`.
- `start` is ignored while `busy`=1.
- `NUM_RANDOM`=0: CORNER goes directly to DRAIN.
- `LATENCY`=0: DRAIN is skipped and the FSM goes directly to DONE.
- Reset, including mid-run, forces the following:
  - state = IDLE
  - `a`, `b`, `cin`, `ref`, `ref_valid`, `busy`, `done`, `vec_count` = 0
  - delay line cleared
  - LFSR = `SEED`

## Timing
- On the edge that samples `start`=1, vector 0 loads onto `a`/`b`/`cin`. Vectors then follow on consecutive cycles with no gaps, N = 6+`NUM_RANDOM` vectors in total.
- `ref` and `ref_valid` in cycle t+`LATENCY` reflect the vector shown in cycle t.
- `ref_valid` is high for exactly N consecutive cycles. When `ref_valid`=0, `ref` is 0.
- `busy` rises with vector 0 and falls after the last `ref_valid` cycle.
- `done` rises in the cycle after the last `ref_valid` cycle, in the same cycle `busy` falls.
- `start` in DONE clears `done` on the same edge that loads vector 0.

## Structure
- Shared package `adder_test_pkg` holds:
  - the state enum (IDLE, CORNER, RANDOM, DRAIN, DONE)
  - `NUM_CORNER`=6
  - `LFSR_MASK`
  - `LFSR_W`=32
- Sub-module `adder_ref_delay`: a parameterised `LATENCY`-stage shift register carrying {valid, ref}.
  - Asynchronous reset to 0.
  - With `LATENCY`=0 it is a wire-through.
- The top level contains the FSM, the corner ROM case, the LFSR and the counters.

## Test plan
- **Reset:** assert `rst` mid-RANDOM → all outputs 0 immediately. After release with `start`, the corner sequence restarts from vector 0 and the LFSR restarts from `SEED`.
- **Corner sums** (`WIDTH`=16, `LATENCY`=1, `start` pulse): `ref` sequence, one cycle after the respective operands, is 17'h00000, 17'h10000, 17'h1FFFF, 17'h0FFFF, 17'h10000, 17'h10000.
- **First random vectors:** vector 6 is a=16'h2468, b=16'hACE1, cin=1, ref=17'h0D14A. Vector 7 is a=16'h9234, b=16'h5670, cin=0, ref=17'h0E8A4.
- **Counts and flags** (`NUM_RANDOM`=64):
  - `ref_valid` is high for exactly 70 cycles.
  - `vec_count` ends at 70.
  - `done` rises in the cycle after the last `ref_valid` cycle and stays high.
  - `start` pulses during `busy` have no effect.
- **Corner cases of parameters:**
  - `LATENCY`=0, `NUM_RANDOM`=0: 6 vectors, `ref` valid in the same cycle as its operands, `done` in the cycle after the last vector.
  - `LATENCY`=3: first `ref_valid` appears 3 cycles after vector 0.
- **Back-to-back runs:** `start` in DONE → the second run's `ref` stream is identical to the first run's.

Source files
------------

// File: rtl/adder_test_pkg.sv
`default_nettype none
// ============================================================================
// Module   : adder_test_pkg
// Purpose  : Shared types and constants for the adder stimulus generator.
//            Contains the sequencer state enum, the corner-set size and the
//            LFSR definition, plus one LFSR step helper.
// Revision : 1.0 - initial release
// ============================================================================
package adder_test_pkg;

  localparam int NUM_CORNER = 6;
  localparam int LFSR_W     = 32;
  localparam logic [LFSR_W-1:0] LFSR_MASK = 32'h8020_0003;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    CORNER = 3'd1,
    RANDOM = 3'd2,
    DRAIN  = 3'd3,
    DONE   = 3'd4
  } state_t;

  // One Galois step: shift right, fold the mask back in when a 1 falls out.
  function automatic logic [LFSR_W-1:0] lfsr_step(input logic [LFSR_W-1:0] l);
    logic [LFSR_W-1:0] n;
    n = l >> 1;
    if (l[0]) n = n ^ LFSR_MASK;
    return n;
  endfunction

endpackage
`default_nettype wire

// File: rtl/adder_ref_delay.sv
`default_nettype none
// ============================================================================
// Module   : adder_ref_delay
// Purpose  : LATENCY-stage shift register carrying {valid, ref} so the
//            expected sum lines up with the adder's registered result.
//            LATENCY = 0 degenerates to a wire-through.
// Revision : 1.0 - initial release
// ============================================================================
module adder_ref_delay #(
  parameter int LATENCY = 1,
  parameter int DW      = 18
) (
  input  logic          clk,
  input  logic          rst,
  input  logic [DW-1:0] din,
  output logic [DW-1:0] dout
);

  if (LATENCY == 0) begin : g_wire
    logic unused_clk_rst;
    assign unused_clk_rst = clk ^ rst;
    assign dout = din;
  end else begin : g_pipe
    logic [DW-1:0] stages [LATENCY];

    // Shift the payload one stage per cycle; reset flushes every stage.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        for (int i = 0; i < LATENCY; i++) stages[i] <= '0;
      end else begin
        stages[0] <= din;
        for (int i = 1; i < LATENCY; i++) stages[i] <= stages[i-1];
      end
    end

    assign dout = stages[LATENCY-1];
  end

endmodule
`default_nettype wire

// File: rtl/adder_stimulus_gen.sv
`default_nettype none
// ============================================================================
// Module   : adder_stimulus_gen
// Purpose  : Drives operand vectors (6 corners, then NUM_RANDOM LFSR vectors)
//            into an adder under test, one per cycle, and produces the
//            matching expected sum delayed by LATENCY cycles.
//            The expected-sum port is named ref_sum because "ref" is a
//            reserved word in SystemVerilog.
// Revision : 1.0 - initial release
// ============================================================================
module adder_stimulus_gen
  import adder_test_pkg::*;
#(
  parameter int          WIDTH      = 16,
  parameter int          LATENCY    = 1,
  parameter int          NUM_RANDOM = 64,
  parameter logic [31:0] SEED       = 32'hACE1_2468
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  output logic [WIDTH-1:0] a,
  output logic [WIDTH-1:0] b,
  output logic             cin,
  output logic [WIDTH:0]   ref_sum,
  output logic             ref_valid,
  output logic             busy,
  output logic             done,
  output logic [15:0]      vec_count
);

  localparam logic [WIDTH-1:0] ALL_ONES     = {WIDTH{1'b1}};
  localparam logic [WIDTH-1:0] MSB_ONLY     = WIDTH'(1) << (WIDTH - 1);
  localparam logic [15:0]      ALT16        = 16'hAAAA;
  localparam logic [WIDTH-1:0] ALT          = ALT16[WIDTH-1:0];
  localparam logic [2:0]       NUM_CORNER_W = 3'(NUM_CORNER);
  localparam logic [15:0]      NUM_RANDOM_W = 16'(NUM_RANDOM);
  localparam logic [15:0]      LATENCY_W    = 16'(LATENCY);

  state_t              state, state_nxt;
  logic [WIDTH-1:0]    a_nxt, b_nxt;
  logic                cin_nxt;
  logic                vec_valid, vec_valid_nxt;
  logic [LFSR_W-1:0]   lfsr, lfsr_nxt;
  logic [2:0]          corner_idx, corner_idx_nxt;
  logic [15:0]         rnd_cnt, rnd_cnt_nxt;
  logic [15:0]         drain_cnt, drain_cnt_nxt;
  logic [15:0]         vec_count_nxt;
  logic [WIDTH-1:0]    rnd_a, rnd_b;
  logic                rnd_cin;
  logic [WIDTH:0]      sum;
  logic [WIDTH+1:0]    dly_in, dly_out;

  // Corner ROM: fixed directed vectors packed as {a, b, cin}.
  function automatic logic [2*WIDTH:0] corner_vec(input logic [2:0] idx);
    logic [2*WIDTH:0] v;
    case (idx)
      3'd0:    v = {{WIDTH{1'b0}}, {WIDTH{1'b0}}, 1'b0};
      3'd1:    v = {ALL_ONES, WIDTH'(1), 1'b0};
      3'd2:    v = {ALL_ONES, ALL_ONES, 1'b1};
      3'd3:    v = {ALT, ~ALT, 1'b0};
      3'd4:    v = {ALT, ~ALT, 1'b1};
      3'd5:    v = {MSB_ONLY, MSB_ONLY, 1'b0};
      default: v = '0;
    endcase
    return v;
  endfunction

  assign rnd_a   = lfsr[WIDTH-1:0];
  assign rnd_b   = lfsr[16+WIDTH-1:16];
  assign rnd_cin = lfsr[31] ^ lfsr[0];

  // Next-state, next-vector and counter logic for the run sequencer.
  always_comb begin
    state_nxt      = state;
    a_nxt          = '0;
    b_nxt          = '0;
    cin_nxt        = 1'b0;
    vec_valid_nxt  = 1'b0;
    lfsr_nxt       = lfsr;
    corner_idx_nxt = corner_idx;
    rnd_cnt_nxt    = rnd_cnt;
    drain_cnt_nxt  = drain_cnt;
    vec_count_nxt  = vec_valid ? vec_count + 16'd1 : vec_count;

    unique case (state)
      IDLE, DONE: begin
        if (start) begin
          state_nxt                 = CORNER;
          {a_nxt, b_nxt, cin_nxt}   = corner_vec(3'd0);
          vec_valid_nxt             = 1'b1;
          corner_idx_nxt            = 3'd1;
          rnd_cnt_nxt               = '0;
          drain_cnt_nxt             = '0;
          lfsr_nxt                  = SEED;
          vec_count_nxt             = '0;
        end
      end
      CORNER: begin
        if (corner_idx < NUM_CORNER_W) begin
          {a_nxt, b_nxt, cin_nxt} = corner_vec(corner_idx);
          vec_valid_nxt           = 1'b1;
          corner_idx_nxt          = corner_idx + 3'd1;
        end else if (NUM_RANDOM > 0) begin
          state_nxt     = RANDOM;
          a_nxt         = rnd_a;
          b_nxt         = rnd_b;
          cin_nxt       = rnd_cin;
          vec_valid_nxt = 1'b1;
          lfsr_nxt      = lfsr_step(lfsr);
          rnd_cnt_nxt   = 16'd1;
        end else if (LATENCY == 0) begin
          state_nxt = DONE;
        end else begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = 16'd1;
        end
      end
      RANDOM: begin
        if (rnd_cnt < NUM_RANDOM_W) begin
          a_nxt         = rnd_a;
          b_nxt         = rnd_b;
          cin_nxt       = rnd_cin;
          vec_valid_nxt = 1'b1;
          lfsr_nxt      = lfsr_step(lfsr);
          rnd_cnt_nxt   = rnd_cnt + 16'd1;
        end else if (LATENCY == 0) begin
          state_nxt = DONE;
        end else begin
          state_nxt     = DRAIN;
          drain_cnt_nxt = 16'd1;
        end
      end
      DRAIN: begin
        // Hold off DONE until the last vector's sum has left the delay line.
        if (drain_cnt >= LATENCY_W) state_nxt = DONE;
        else                        drain_cnt_nxt = drain_cnt + 16'd1;
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, operand and counter registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      a          <= '0;
      b          <= '0;
      cin        <= 1'b0;
      vec_valid  <= 1'b0;
      lfsr       <= SEED;
      corner_idx <= '0;
      rnd_cnt    <= '0;
      drain_cnt  <= '0;
      vec_count  <= '0;
    end else begin
      state      <= state_nxt;
      a          <= a_nxt;
      b          <= b_nxt;
      cin        <= cin_nxt;
      vec_valid  <= vec_valid_nxt;
      lfsr       <= lfsr_nxt;
      corner_idx <= corner_idx_nxt;
      rnd_cnt    <= rnd_cnt_nxt;
      drain_cnt  <= drain_cnt_nxt;
      vec_count  <= vec_count_nxt;
    end
  end

  // Full-width expected sum; forced to zero when no vector is on the bus.
  assign sum    = {1'b0, a} + {1'b0, b} + {{WIDTH{1'b0}}, cin};
  assign dly_in = {vec_valid, vec_valid ? sum : {(WIDTH+1){1'b0}}};

  adder_ref_delay #(
    .LATENCY (LATENCY),
    .DW      (WIDTH + 2)
  ) u_ref_delay (
    .clk  (clk),
    .rst  (rst),
    .din  (dly_in),
    .dout (dly_out)
  );

  assign ref_valid = dly_out[WIDTH+1];
  assign ref_sum   = dly_out[WIDTH:0];
  assign busy      = (state == CORNER) || (state == RANDOM) || (state == DRAIN);
  assign done      = (state == DONE);

endmodule
`default_nettype wire

// File: tb/tb_adder_stimulus_gen.sv
`default_nettype none
// ============================================================================
// Module   : tb_adder_stimulus_gen
// Purpose  : Self-checking bench for adder_stimulus_gen across three
//            parameter sets, against a vector-list reference model.
// Revision : 1.0 - initial release
// ============================================================================
module tb_adder_stimulus_gen;

  localparam logic [31:0] SEED = 32'hACE1_2468;
  localparam logic [31:0] MASK = 32'h8020_0003;

  logic clk = 1'b0;
  logic rst;
  logic start0, start1, start2;
  int   total = 0;
  int   bad   = 0;

  // d0: WIDTH=16, LATENCY=1, NUM_RANDOM=64
  logic [15:0] a0, b0; logic cin0; logic [16:0] ref0; logic rv0, busy0, done0; logic [15:0] cnt0;
  // d1: WIDTH=16, LATENCY=0, NUM_RANDOM=0
  logic [15:0] a1, b1; logic cin1; logic [16:0] ref1; logic rv1, busy1, done1; logic [15:0] cnt1;
  // d2: WIDTH=8, LATENCY=3, NUM_RANDOM=5
  logic [7:0]  a2, b2; logic cin2; logic [8:0]  ref2; logic rv2, busy2, done2; logic [15:0] cnt2;

  always #5 clk = ~clk;

  adder_stimulus_gen #(.WIDTH(16), .LATENCY(1), .NUM_RANDOM(64), .SEED(SEED)) d0 (
    .clk(clk), .rst(rst), .start(start0), .a(a0), .b(b0), .cin(cin0), .ref_sum(ref0),
    .ref_valid(rv0), .busy(busy0), .done(done0), .vec_count(cnt0));
  adder_stimulus_gen #(.WIDTH(16), .LATENCY(0), .NUM_RANDOM(0), .SEED(SEED)) d1 (
    .clk(clk), .rst(rst), .start(start1), .a(a1), .b(b1), .cin(cin1), .ref_sum(ref1),
    .ref_valid(rv1), .busy(busy1), .done(done1), .vec_count(cnt1));
  adder_stimulus_gen #(.WIDTH(8), .LATENCY(3), .NUM_RANDOM(5), .SEED(SEED)) d2 (
    .clk(clk), .rst(rst), .start(start2), .a(a2), .b(b2), .cin(cin2), .ref_sum(ref2),
    .ref_valid(rv2), .busy(busy2), .done(done2), .vec_count(cnt2));

  // sel: 0 a, 1 b, 2 cin, 3 ref, 4 ref_valid, 5 busy, 6 done, 7 vec_count
  function automatic logic [31:0] obs(input int d, input int sel);
    logic [31:0] v [8];
    case (d)
      0: begin
        v[0] = 32'(a0); v[1] = 32'(b0); v[2] = 32'(cin0); v[3] = 32'(ref0);
        v[4] = 32'(rv0); v[5] = 32'(busy0); v[6] = 32'(done0); v[7] = 32'(cnt0);
      end
      1: begin
        v[0] = 32'(a1); v[1] = 32'(b1); v[2] = 32'(cin1); v[3] = 32'(ref1);
        v[4] = 32'(rv1); v[5] = 32'(busy1); v[6] = 32'(done1); v[7] = 32'(cnt1);
      end
      default: begin
        v[0] = 32'(a2); v[1] = 32'(b2); v[2] = 32'(cin2); v[3] = 32'(ref2);
        v[4] = 32'(rv2); v[5] = 32'(busy2); v[6] = 32'(done2); v[7] = 32'(cnt2);
      end
    endcase
    return v[sel];
  endfunction

  task automatic check(input string tag, input logic [31:0] o, input logic [31:0] e);
    total++;
    assert (o === e) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, o, e);
    end
  endtask

  task automatic set_start(input int d, input logic v);
    case (d)
      0:       start0 = v;
      1:       start1 = v;
      default: start2 = v;
    endcase
  endtask

  task automatic check_all_zero(input int d, input string tag);
    for (int s = 0; s < 8; s++)
      check($sformatf("%s d%0d sel%0d", tag, d, s), obs(d, s), 32'd0);
  endtask

  // Starts a run on DUT d (called at a falling edge) and checks every output
  // cycle by cycle against a vector list built from the corner/LFSR rules.
  // With poke set, start is pulsed mid-run; the stream must be unaffected.
  task automatic check_run(input int d, input int w, input int nr, input int lat, input bit poke);
    int          n;
    logic [31:0] va[$], vb[$], vc[$];
    logic [31:0] l, msk, alt, msb;
    logic [31:0] ea, eb, ec, eref;
    bit          rv, eb_busy;
    n   = 6 + nr;
    msk = (32'd1 << w) - 32'd1;
    msb = 32'd1 << (w - 1);
    alt = 0;
    for (int i = 1; i < w; i += 2) alt = alt | (32'd1 << i);
    va = {32'd0, msk, msk, alt, alt, msb};
    vb = {32'd0, 32'd1, msk, (~alt) & msk, (~alt) & msk, msb};
    vc = {32'd0, 32'd0, 32'd1, 32'd0, 32'd1, 32'd0};
    l = SEED;
    for (int k = 0; k < nr; k++) begin
      va.push_back(l & msk);
      vb.push_back((l >> 16) & msk);
      vc.push_back({31'd0, l[31] ^ l[0]});
      l = l[0] ? ((l >> 1) ^ MASK) : (l >> 1);
    end

    set_start(d, 1'b1);
    @(negedge clk);
    set_start(d, 1'b0);
    for (int c = 0; c <= n + lat + 2; c++) begin
      ea      = (c < n) ? va[c] : 32'd0;
      eb      = (c < n) ? vb[c] : 32'd0;
      ec      = (c < n) ? vc[c] : 32'd0;
      rv      = (c >= lat) && (c < n + lat);
      eref    = rv ? (va[c-lat] + vb[c-lat] + vc[c-lat]) : 32'd0;
      eb_busy = (c < n + lat);
      check($sformatf("d%0d c%0d a", d, c),     obs(d, 0), ea);
      check($sformatf("d%0d c%0d b", d, c),     obs(d, 1), eb);
      check($sformatf("d%0d c%0d cin", d, c),   obs(d, 2), ec);
      check($sformatf("d%0d c%0d ref", d, c),   obs(d, 3), eref);
      check($sformatf("d%0d c%0d rv", d, c),    obs(d, 4), 32'(rv));
      check($sformatf("d%0d c%0d busy", d, c),  obs(d, 5), 32'(eb_busy));
      check($sformatf("d%0d c%0d done", d, c),  obs(d, 6), 32'(!eb_busy));
      if (poke && c == 20) set_start(d, 1'b1);
      if (poke && c == 21) set_start(d, 1'b0);
      @(negedge clk);
    end
    check($sformatf("d%0d vec_count end", d), obs(d, 7), 32'(n));
    check($sformatf("d%0d done held", d),     obs(d, 6), 32'd1);
  endtask

  initial begin
    rst    = 1'b1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
    repeat (3) @(negedge clk);
    for (int d = 0; d < 3; d++) check_all_zero(d, "reset");
    rst = 1'b0;
    @(negedge clk);

    // Main run with a start pulse while busy, then a back-to-back rerun.
    check_run(0, 16, 64, 1, 1'b1);
    check_run(0, 16, 64, 1, 1'b0);

    // Parameter corner cases.
    check_run(1, 16, 0, 0, 1'b0);
    check_run(2, 8, 5, 3, 1'b0);

    // Reset in the middle of the random phase, then a clean restart.
    set_start(0, 1'b1);
    @(negedge clk);
    set_start(0, 1'b0);
    repeat (30) @(negedge clk);
    rst = 1'b1;
    #1;
    check_all_zero(0, "midrun_rst");
    @(negedge clk);
    rst = 1'b0;
    @(negedge clk);
    check_run(0, 16, 64, 1, 1'b0);

    // Random-length idle gap, then the short-config run must still match.
    repeat ($urandom_range(1, 8)) @(negedge clk);
    check_run(2, 8, 5, 3, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
`default_nettype wire
